// File: rtl/clint_rtc_pkg.sv
// Shared types and constants for the CLINT RTC tick generator.
// CATCHUP_MAX and MISS_W are used only when CLINT_RTC_CATCHUP_EN is defined.
package clint_rtc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } rtc_state_e;

  localparam longint unsigned F_ACLK_HZ_DEF  = 64'd50_000_000;
  localparam longint unsigned F_MTIME_HZ_DEF = 64'd1_000_000;

  localparam int unsigned CATCHUP_MAX = 255;
  localparam int unsigned MISS_W      = $clog2(CATCHUP_MAX + 1);

  // Two overflows per mtime tick (rtc_o is a square wave), rounded to nearest.
  // Exact only while (2 * f_mtime_hz) << acc_width still fits in 64 bits.
  function automatic longint unsigned inc_default_calc(input longint unsigned f_aclk_hz,
                                                       input longint unsigned f_mtime_hz,
                                                       input int unsigned     acc_width);
    longint unsigned num;
    num = (64'd2 * f_mtime_hz) << acc_width;
    return (num + (f_aclk_hz / 64'd2)) / f_aclk_hz;
  endfunction

endpackage

// File: rtl/clint_rtc_tick_gen_if.sv
// Increment/halt control and RTC outputs of the tick generator.
interface clint_rtc_tick_gen_if #(
  parameter int unsigned ACC_WIDTH = 32
);
  logic [ACC_WIDTH-1:0] inc_i;
  logic                 inc_valid_i;
  logic                 halt_i;
  logic                 rtc_o;
  logic                 tick_o;
  logic                 inc_pending_o;

  modport master (
    output inc_i, inc_valid_i, halt_i,
    input  rtc_o, tick_o, inc_pending_o
  );

  modport slave (
    input  inc_i, inc_valid_i, halt_i,
    output rtc_o, tick_o, inc_pending_o
  );
endinterface

// File: rtl/clint_rtc_phase_acc.sv
// Phase accumulator with deferred increment reload.
// CLINT_RTC_CATCHUP_EN adds a shadow accumulator that keeps running while halted.
module clint_rtc_phase_acc #(
  parameter int unsigned          ACC_WIDTH   = 32,
  parameter logic [ACC_WIDTH-1:0] INC_DEFAULT = '0
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 acc_en_i,
`ifdef CLINT_RTC_CATCHUP_EN
  input  logic                 shadow_init_i,
  input  logic                 shadow_en_i,
  input  logic                 shadow_commit_i,
  output logic                 shadow_carry_c,
`endif
  input  logic [ACC_WIDTH-1:0] inc_i,
  input  logic                 inc_valid_i,
  output logic                 carry_c,
  output logic                 inc_pending_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [ACC_WIDTH-1:0] inc_nxt_q, inc_nxt_d;
  logic                 inc_pending_q, inc_pending_d;
  logic [ACC_WIDTH:0]   sum_c;
`ifdef CLINT_RTC_CATCHUP_EN
  logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
  logic [ACC_WIDTH:0]   shadow_sum_c;
`endif

  // Reload lands on an overflow, or at once when a zero increment would never overflow.
  always_comb begin : acc_comb
    acc_d         = acc_q;
    inc_d         = inc_q;
    inc_nxt_d     = inc_nxt_q;
    inc_pending_d = inc_pending_q;
    sum_c         = {1'b0, acc_q} + {1'b0, inc_q};
    carry_c       = acc_en_i & sum_c[ACC_WIDTH];
    if (acc_en_i) acc_d = sum_c[ACC_WIDTH-1:0];
    if (acc_en_i && inc_pending_q && (sum_c[ACC_WIDTH] || (inc_q == '0))) begin
      inc_d         = inc_nxt_q;
      inc_pending_d = 1'b0;
    end
    if (inc_valid_i) begin
      inc_nxt_d     = inc_i;
      inc_pending_d = 1'b1;
    end
`ifdef CLINT_RTC_CATCHUP_EN
    shadow_d       = shadow_q;
    shadow_sum_c   = {1'b0, shadow_q} + {1'b0, inc_q};
    shadow_carry_c = shadow_en_i & shadow_sum_c[ACC_WIDTH];
    if (shadow_init_i)    shadow_d = acc_q;
    else if (shadow_en_i) shadow_d = shadow_sum_c[ACC_WIDTH-1:0];
    if (shadow_commit_i)  acc_d    = shadow_sum_c[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge aclk) begin : acc_regs
    if (areset) begin
      acc_q         <= '0;
      inc_q         <= INC_DEFAULT;
      inc_nxt_q     <= '0;
      inc_pending_q <= 1'b0;
`ifdef CLINT_RTC_CATCHUP_EN
      shadow_q      <= '0;
`endif
    end else begin
      acc_q         <= acc_d;
      inc_q         <= inc_d;
      inc_nxt_q     <= inc_nxt_d;
      inc_pending_q <= inc_pending_d;
`ifdef CLINT_RTC_CATCHUP_EN
      shadow_q      <= shadow_d;
`endif
    end
  end

  assign inc_pending_o = inc_pending_q;

endmodule

// File: rtl/clint_rtc_tick_gen.sv
// RTC toggle generator for the CLINT: fractional divider, halt freeze and tick pulse.
// CLINT_RTC_CATCHUP_EN replays overflows missed during halt after release.
module clint_rtc_tick_gen
  import clint_rtc_pkg::*;
#(
  parameter int unsigned          ACC_WIDTH   = 32,
  parameter logic [ACC_WIDTH-1:0] INC_DEFAULT =
    ACC_WIDTH'(inc_default_calc(F_ACLK_HZ_DEF, F_MTIME_HZ_DEF, ACC_WIDTH))
) (
  input  logic                 aclk,
  input  logic                 areset,
  clint_rtc_tick_gen_if.slave  bus
);

  rtc_state_e state_q, state_d;
  logic       acc_en_c;
  logic       carry_c;
  logic       toggle_c;
  logic       rtc_q, rtc_d;
  logic       tick_q, tick_d;
`ifdef CLINT_RTC_CATCHUP_EN
  logic              shadow_init_c, shadow_en_c, shadow_commit_c, shadow_carry_c;
  logic              catchup_c, force_c, cnt_up_c;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              cu_phase_q, cu_phase_d;
`endif

  always_ff @(posedge aclk) begin : state_reg
    if (areset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.halt_i)  state_d = HALT;
      HALT:    if (!bus.halt_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The add is suppressed on the halt-entry edge and on the halt-exit edge.
  always_comb begin : fsm_out
    acc_en_c        = (state_q == RUN) && !bus.halt_i;
`ifdef CLINT_RTC_CATCHUP_EN
    shadow_init_c   = (state_q == RUN) && bus.halt_i;
    shadow_en_c     = (state_q == HALT);
    shadow_commit_c = (state_q == HALT) && !bus.halt_i;
`endif
  end

  clint_rtc_phase_acc #(
    .ACC_WIDTH   (ACC_WIDTH),
    .INC_DEFAULT (INC_DEFAULT)
  ) u_phase_acc (
    .aclk            (aclk),
    .areset          (areset),
    .acc_en_i        (acc_en_c),
`ifdef CLINT_RTC_CATCHUP_EN
    .shadow_init_i   (shadow_init_c),
    .shadow_en_i     (shadow_en_c),
    .shadow_commit_i (shadow_commit_c),
    .shadow_carry_c  (shadow_carry_c),
`endif
    .inc_i           (bus.inc_i),
    .inc_valid_i     (bus.inc_valid_i),
    .carry_c         (carry_c),
    .inc_pending_o   (bus.inc_pending_o)
  );

  always_comb begin : rtc_comb
    toggle_c = carry_c;
`ifdef CLINT_RTC_CATCHUP_EN
    // While misses are owed, live overflows join the backlog and edges come every other cycle.
    catchup_c  = (miss_q != '0);
    force_c    = acc_en_c & catchup_c & cu_phase_q;
    cnt_up_c   = shadow_carry_c | (carry_c & catchup_c);
    toggle_c   = force_c | (carry_c & ~catchup_c);
    cu_phase_d = catchup_c & (cu_phase_q ^ acc_en_c);
    miss_d     = miss_q;
    if (cnt_up_c && !force_c) begin
      if (miss_q != MISS_W'(CATCHUP_MAX)) miss_d = miss_q + MISS_W'(1);
    end else if (force_c && !cnt_up_c) begin
      miss_d = miss_q - MISS_W'(1);
    end
`endif
    rtc_d  = rtc_q ^ toggle_c;
    tick_d = toggle_c & ~rtc_q;
  end

  always_ff @(posedge aclk) begin : rtc_regs
    if (areset) begin
      rtc_q      <= 1'b0;
      tick_q     <= 1'b0;
`ifdef CLINT_RTC_CATCHUP_EN
      miss_q     <= '0;
      cu_phase_q <= 1'b0;
`endif
    end else begin
      rtc_q      <= rtc_d;
      tick_q     <= tick_d;
`ifdef CLINT_RTC_CATCHUP_EN
      miss_q     <= miss_d;
      cu_phase_q <= cu_phase_d;
`endif
    end
  end

  assign bus.rtc_o  = rtc_q;
  assign bus.tick_o = tick_q;

endmodule

// File: tb/tb_clint_rtc_tick_gen.sv
// Directed bench for clint_rtc_tick_gen at ACC_WIDTH=8, INC_DEFAULT=64.
// With CLINT_RTC_CATCHUP_EN defined, the post-halt expectations follow the replay behaviour.
module tb_clint_rtc_tick_gen;

  typedef struct packed {
    logic rtc;
    logic tick;
    logic pend;
  } exp_t;

  logic aclk = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;
  logic e_rtc;
  exp_t sb_q[$];

  clint_rtc_tick_gen_if #(.ACC_WIDTH(8)) bus_if ();

  clint_rtc_tick_gen #(
    .ACC_WIDTH   (8),
    .INC_DEFAULT (8'd64)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus_if)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input string fld, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %b expected %b", tag, fld, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, queue the expected outputs, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic v, input logic [7:0] inc,
                      input logic h, input logic tgl, input logic pend);
    exp_t e;
    exp_t got;
    areset             = rst;
    bus_if.inc_valid_i = v;
    bus_if.inc_i       = inc;
    bus_if.halt_i      = h;
    if (rst) begin
      e     = '0;
      e_rtc = 1'b0;
    end else begin
      e.rtc  = e_rtc ^ tgl;
      e.tick = tgl & ~e_rtc;
      e.pend = pend;
      e_rtc  = e.rtc;
    end
    sb_q.push_back(e);
    @(posedge aclk);
    #1;
    got = {bus_if.rtc_o, bus_if.tick_o, bus_if.inc_pending_o};
    e   = sb_q.pop_front();
    chk(tag, "rtc_o", got.rtc, e.rtc);
    chk(tag, "tick_o", got.tick, e.tick);
    chk(tag, "inc_pending_o", got.pend, e.pend);
  endtask

  initial begin
    areset             = 1'b1;
    bus_if.inc_i       = '0;
    bus_if.inc_valid_i = 1'b0;
    bus_if.halt_i      = 1'b0;
    e_rtc              = 1'b0;

    repeat (2) step("reset", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Default increment 64: first rise after 4 edges, period 8.
    for (int k = 1; k <= 24; k++) step("t1_run", 1'b0, 1'b0, 8'd0, 1'b0, (k % 4) == 0, 1'b0);

    // Halt with acc at 64, then resume from the frozen phase.
    step("t4_pre", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (20) step("t4_halt", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    step("t4_exit", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
`ifdef CLINT_RTC_CATCHUP_EN
    // 5 missed plus live overflows replayed at 2-cycle spacing, then a direct overflow.
    for (int n = 1; n <= 19; n++)
      step("t5_replay", 1'b0, 1'b0, 8'd0, 1'b0, ((n % 2) == 0) || (n == 19), 1'b0);
`else
    for (int n = 1; n <= 3; n++) step("t4_resume", 1'b0, 1'b0, 8'd0, 1'b0, n == 3, 1'b0);
`endif

    // Reload 128 mid-period; pending until the next overflow.
    step("t2_a1", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step("t2_load", 1'b0, 1'b1, 8'd128, 1'b0, 1'b0, 1'b1);
    step("t2_wait", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    step("t2_apply", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 8; n++) step("t2_fast", 1'b0, 1'b0, 8'd0, 1'b0, (n % 2) == 0, 1'b0);

    // Strobe on an overflow edge is held over to the following overflow.
    step("t2_a13", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step("t2_same", 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
    step("t2_hold", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    step("t2_zero", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

    // Zero increment freezes rtc_o.
    repeat (1000) step("t3_frozen", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // From zero the reload takes effect on the next cycle.
    step("t3_load", 1'b0, 1'b1, 8'd32, 1'b0, 1'b0, 1'b1);
    step("t3_apply", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 16; n++) step("t3_run32", 1'b0, 1'b0, 8'd0, 1'b0, (n % 8) == 0, 1'b0);

    // Back-to-back strobes: the last value (64) wins.
    step("t2_b2b_a", 1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 1'b1);
    step("t2_b2b_b", 1'b0, 1'b1, 8'd64, 1'b0, 1'b0, 1'b1);
    for (int n = 3; n <= 8; n++) step("t2_b2b_wait", 1'b0, 1'b0, 8'd0, 1'b0, n == 8, n < 8);
    for (int n = 1; n <= 8; n++) step("t2_run64", 1'b0, 1'b0, 8'd0, 1'b0, (n % 4) == 0, 1'b0);

    // Reset during halt with a pending increment.
    step("t6_halt", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    step("t6_load", 1'b0, 1'b1, 8'd16, 1'b1, 1'b0, 1'b1);
    step("t6_hold", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    step("t6_reset", 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 8; n++) step("t6_after", 1'b0, 1'b0, 8'd0, 1'b0, (n % 4) == 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
